mux_reg_arb: RTL
================

# mux_reg_arb

Parametrised N-channel, W-bit registered multiplexer with valid/ready flow control on every input and on the output. One input channel is selected per cycle (by control input, or by round-robin arbitration when compiled in), and its word is captured into a single-entry output register that holds until the downstream consumer accepts it. It is the generalised successor of the team's fixed 4:1 × 16-bit registered mux. It sits between several producer streams and one shared consumer.

## Interface
- `WIDTH`, default 16: data width per channel, ≥ 1.
- `CHANNELS`, default 4: number of input channels, ≥ 2.
- `SEL_W` (localparam): `$clog2(CHANNELS)`.
- `i_clk`  input  1: clock; all state updates on the rising edge.
- `i_rst`  input  1: synchronous, active-high reset.
- `i_data`  input  CHANNELS*WIDTH: packed channel data; channel k occupies `[k*WIDTH +: WIDTH]`.
- `i_valid`  input  CHANNELS: per-channel word-valid.
- `o_ready`  output  CHANNELS: per-channel accept, combinational; at most one bit high.
- `i_ctrl`  input  SEL_W: channel select in fixed mode; ignored when round-robin is compiled in.
- `o_data`  output  WIDTH: registered output word.
- `o_valid`  output  1: `o_data` holds an unconsumed word.
- `o_sel`  output  SEL_W: index of the channel that produced `o_data`.
- `i_ready`  input  1: downstream accepts `o_data` this cycle.
- `o_xfer_cnt`  output  16: count of input words captured; wraps at 2^16.

## Operation
- Load enable: `load = !o_valid || i_ready`.
- Candidate channel `s`:
  - Fixed mode: `s = i_ctrl`. If `i_ctrl >= CHANNELS`, there is no candidate.
  - Round-robin mode: described under Configuration.
- Capture: `grant = load && candidate exists && i_valid[s]`.
  - `o_ready[s] = load && candidate exists`. All other `o_ready` bits are 0.
  - A transfer on channel k is `i_valid[k] && o_ready[k]`.
- On a grant, at the next edge:
  - `o_data <= i_data[s]`, `o_sel <= s`, `o_valid <= 1`.
  - `o_xfer_cnt` increments, wrapping from 0xFFFF to 0x0000.
- If `load` is 1 and there is no grant, at the next edge:
  - `o_valid <= 0`.
  - `o_data` and `o_sel` keep their last values.
- Stall (`o_valid && !i_ready`):
  - `o_data`, `o_sel` and `o_valid` are held.
  - All `o_ready` bits are 0.
- Simultaneous consume and capture (`o_valid && i_ready` with a valid candidate): the old word leaves and the new word is loaded in the same edge, with no bubble.
- Reset values:
  - `o_data = 0`, `o_sel = 0`, `o_valid = 0`, `o_xfer_cnt = 0`.
  - Round-robin pointer = `CHANNELS-1`.
- Reset mid-operation discards any held word. `o_ready` is 0 during reset.

## Timing
- Latency: an input transfer in cycle t makes `o_valid` and `o_data` visible in cycle t+1.
- Throughput: 1 word per cycle while `i_ready` stays high.
- `o_ready` depends combinationally on `i_valid`, `i_ctrl`, `i_ready` and registered state only. There is no path from `i_data` to `o_ready`.
- `o_data`, `o_sel`, `o_valid` and `o_xfer_cnt` are pure register outputs.
- Changing `i_ctrl` during a stall has no effect until `load` is 1 again.

## Configuration
- Macro: `MUX_REG_ARB_RR_EN`.
- Defined (round-robin mode):
  - `i_ctrl` is ignored.
  - The candidate is the first channel with `i_valid` high, searching cyclically from pointer+1.
  - On each grant, the pointer is set to the granted index. The pointer is held otherwise.
  - No candidate exists when `i_valid` is all zero.
- Undefined (fixed mode): the pointer logic is not built, and selection follows `i_ctrl`.

## Test plan
- Fixed mode, W=16, N=4:
  - Stimulus: `i_data` = {0x3333, 0x2222, 0x1111, 0x0000}, all valid, `i_ready=1`, `i_ctrl` stepping 0,1,2,3.
  - Response: `o_data` = 0x0000, 0x1111, 0x2222, 0x3333, each one cycle later; `o_sel` = 0..3; `o_xfer_cnt` = 4.
- Stall:
  - Stimulus: capture 0x1111, then hold `i_ready=0` for 3 cycles.
  - Response: `o_data` stays 0x1111, `o_valid` stays 1, `o_ready` is 0; the next word loads on the cycle `i_ready` returns to 1.
- Out-of-range select:
  - Stimulus: N=3, `i_ctrl=3`, all valid.
  - Response: `o_ready` = 0 and `o_valid` falls to 0.
- Round-robin (`MUX_REG_ARB_RR_EN`):
  - Stimulus: N=4, all channels valid continuously.
  - Response: `o_sel` sequence is 0,1,2,3,0.
  - Stimulus: only channels 1 and 3 valid.
  - Response: `o_sel` alternates 1,3,1,3.
- Reset mid-stream:
  - Stimulus: assert `i_rst` for 1 cycle while `o_valid=1` and `o_xfer_cnt=5`.
  - Response: next cycle `o_valid=0`, `o_data=0`, `o_xfer_cnt=0`; round-robin restarts at channel 0.
- Counter wrap:
  - Stimulus: preload the count to 0xFFFF via 65535 transfers, then perform one more transfer.
  - Response: `o_xfer_cnt = 0x0000`.

Source files
------------

// File: rtl/mux_reg_arb.sv
// N-channel registered multiplexer with valid/ready flow control on every port.
// Define MUX_REG_ARB_RR_EN to select channels by round-robin instead of i_ctrl.
module mux_reg_arb #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic [SEL_W-1:0]          i_ctrl,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    output logic [SEL_W-1:0]          o_sel,
    input  logic                      i_ready,
    output logic [15:0]               o_xfer_cnt
);

    logic [WIDTH-1:0] data_r;
    logic [SEL_W-1:0] sel_r;
    logic             valid_r;
    logic [15:0]      cnt_r;

    logic             load_s;
    logic [SEL_W-1:0] cand_s;
    logic             cand_ok_s;
    logic             cand_valid_s;
    logic [WIDTH-1:0] cand_data_s;
    logic             grant_s;

    assign load_s = !valid_r || i_ready;

`ifdef MUX_REG_ARB_RR_EN
    logic [SEL_W-1:0] ptr_r;
    logic             unused_ctrl_s;

    assign unused_ctrl_s = ^i_ctrl;

    // Reduce (base) modulo CHANNELS; base never exceeds 2*CHANNELS-1.
    function automatic logic [SEL_W-1:0] wrap_idx(input int base);
        if (base >= CHANNELS) begin
            return SEL_W'(base - CHANNELS);
        end else begin
            return SEL_W'(base);
        end
    endfunction

    // Search downward so the channel nearest to ptr_r+1 is the last one assigned.
    always_comb begin
        cand_s    = '0;
        cand_ok_s = 1'b0;
        for (int i = CHANNELS; i >= 1; i--) begin
            if (i_valid[wrap_idx(int'(ptr_r) + i)]) begin
                cand_s    = wrap_idx(int'(ptr_r) + i);
                cand_ok_s = 1'b1;
            end else begin
                cand_s    = cand_s;
                cand_ok_s = cand_ok_s;
            end
        end
    end

    // Pointer remembers the last granted channel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_r <= SEL_W'(CHANNELS - 1);
        end else if (grant_s) begin
            ptr_r <= cand_s;
        end
    end
`else
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    // Fixed selection: a select code beyond the last channel names no candidate.
    always_comb begin
        cand_s    = i_ctrl;
        cand_ok_s = ({1'b0, i_ctrl} < CH_LIMIT);
    end
`endif

    // Pick valid bit and word of the candidate; out-of-range codes match nothing.
    always_comb begin
        cand_valid_s = 1'b0;
        cand_data_s  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cand_s == SEL_W'(k)) begin
                cand_valid_s = i_valid[k];
                cand_data_s  = i_data[k*WIDTH +: WIDTH];
            end else begin
                cand_valid_s = cand_valid_s;
                cand_data_s  = cand_data_s;
            end
        end
    end

    assign grant_s = load_s && cand_ok_s && cand_valid_s;

    // Offer acceptance to the candidate only; never depends on i_data.
    always_comb begin
        o_ready = '0;
        if (!i_rst && load_s && cand_ok_s) begin
            o_ready[cand_s] = 1'b1;
        end else begin
            o_ready = '0;
        end
    end

    // Single-entry output register and capture counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_r  <= '0;
            sel_r   <= '0;
            valid_r <= 1'b0;
            cnt_r   <= 16'd0;
        end else if (grant_s) begin
            data_r  <= cand_data_s;
            sel_r   <= cand_s;
            valid_r <= 1'b1;
            cnt_r   <= cnt_r + 16'd1;
        end else if (load_s) begin
            valid_r <= 1'b0;
        end
    end

    assign o_data     = data_r;
    assign o_sel      = sel_r;
    assign o_valid    = valid_r;
    assign o_xfer_cnt = cnt_r;

endmodule
